uart_traffic_gen_checker: RTL and testbench
===========================================

# uart_traffic_gen_checker

Self-checking UART traffic source and sink for one `UART_CONTROLLER` port.
- Pushes a programmable burst of pattern words into the controller transmit path through `write_nic`/`data_in`.
- Pops received words through `read_nic_i`/`read_nic` and checks them against an identical, independently advanced pattern.
- Reports counts, first-mismatch details, timeout and pass/fail.
- Wiring two instances to two cross-connected controllers gives a synthesizable, on-chip version of the dual-UART throughput test.

## Interface
- `WORD_SIZE`, default 8: data word width, 1..16.
- `CNT_W`, default 16: width of burst length and of all counters.
- `LFSR_SEED`, default 16'hACE1: nonzero seed for both pattern generators.
- `TIMEOUT_CYCLES`, default 2_000_000: idle-receive cycles allowed in DRAIN before declaring a timeout.
- `clk`  in  1  system clock.
- `rst`  in  1  reset; asynchronous, active-low.
- `start`  in  1  one-cycle pulse that begins a run; honoured in IDLE or DONE only.
- `stop`  in  1  ends a continuous run; SEND→DRAIN.
- `mode`  in  1  pattern select: 0 = LFSR, 1 = incrementing.
- `burst_len`  in  CNT_W  words to send; 0 = continuous until `stop`. Sampled at `start`.
- `tx_full`  in  1  controller TX ring full; blocks `write_nic`.
- `write_nic`  out  1  push `data_in` into the controller this cycle.
- `data_in`  out  WORD_SIZE  word being pushed.
- `read_nic_i`  in  1  controller has a received word available.
- `data_out`  in  WORD_SIZE  head received word.
- `read_nic`  out  1  pop one received word.
- `busy`  out  1  state is SEND or DRAIN.
- `done`  out  1  state is DONE.
- `pass`  out  1  set in DONE when there are no errors and no timeout.
- `timeout`  out  1  DRAIN timer expired.
- `sent_count`, `recv_count`, `err_count`  out  CNT_W each  words pushed, words popped, mismatches.
- `first_err_idx`  out  CNT_W  index of the first mismatching word.
- `first_err_exp`, `first_err_act`  out  WORD_SIZE each  expected and actual values of the first mismatch.

## Operation
- **States:** IDLE, SEND, DRAIN, DONE.
- **IDLE/DONE + `start`:**
  - Clear all counters, flags and first-error fields.
  - Reload both generators.
  - Latch `burst_len` and `mode`.
  - Go to SEND.
- **SEND:**
  - `write_nic = !tx_full && (latched_len==0 || sent_count<latched_len)`.
  - Each push advances the TX generator and increments `sent_count`.
  - Go to DRAIN when `sent_count` reaches the latched length (nonzero length), or on `stop`.
- **DRAIN:**
  - No pushes.
  - Go to DONE when `recv_count == sent_count`.
  - The timer counts cycles since the last pop and resets to 0 on each pop. If it reaches `TIMEOUT_CYCLES`, set `timeout` and go to DONE.
- **Receive (SEND and DRAIN):**
  - When `read_nic_i=1` and `read_nic=0`, compare `data_out` with the checker generator word.
  - Assert `read_nic` for exactly the next cycle.
  - Advance the checker generator and increment `recv_count`.
  - A mismatch increments `err_count`. On the first mismatch only, also latch the index, expected value and actual value.
- **Excess words:** a word received while `recv_count == sent_count` in DRAIN counts as an error.
- **Receive in IDLE/DONE:** words are popped and discarded; counters are not touched.
- **Patterns:**
  - LFSR mode: 16-bit Galois LFSR, mask 16'hB400, shifted right; the word is the low `WORD_SIZE` bits.
  - Incrementing mode: starts at 0 and adds 1 modulo 2^WORD_SIZE.
  - Both generators advance only on their own event.
- **Counters:** all counters saturate at all-ones; `err_count` never wraps.
- **Simultaneous events:**
  - `start` while busy is ignored.
  - `stop` when the burst is already complete has no extra effect.
  - A push and a pop in the same cycle are both counted.

## Timing
- **Reset values:** every output is 0; state is IDLE; both generators hold their reset values.
- **Reset mid-run:** asynchronous assertion returns everything to reset values immediately. No partial word is pushed after reset.
- **Start:** `start` at edge N gives `busy=1` and the first possible `write_nic` in cycle N+1.
- **Push rate:** `write_nic`/`data_in` are combinational from registered state and `tx_full`. Maximum rate is 1 word/cycle.
- **Pop rate:** `read_nic` is registered. Maximum rate is 1 word per 2 cycles.
- **Pass/done:** `pass` and `done` are registered and valid the cycle after entering DONE. They hold until the next `start` or reset.

## Structure
- **Package `uart_tg_pkg`:**
  - State enum.
  - Mode enum.
  - LFSR mask constant.
  - Default `TIMEOUT_CYCLES`.
- **Sub-module `uart_pattern_gen`:**
  - Ports: `clk`, `rst`, `load`, `advance`, `mode`, `word`.
  - Instantiated twice, once for TX and once for the checker.

## Test plan
- `burst_len`=4, LFSR mode, ideal loopback FIFO → `sent_count`=4, `recv_count`=4, `err_count`=0, `pass`=1, `done`=1.
- `burst_len`=8, bench XORs word 2 with 0x01 → `err_count`=1, `first_err_idx`=2, `first_err_act` = `first_err_exp` ^ 0x01, `pass`=0.
- Incrementing mode, `burst_len`=300, `WORD_SIZE`=8 → words wrap 255→0 and 0→…, 0 errors.
- `tx_full` held high for 10 cycles mid-burst of 16 → `write_nic`=0 throughout the stall, `sent_count`=16, `pass`=1.
- Bench drops one word of 6, `TIMEOUT_CYCLES`=50 → `timeout`=1 exactly 50 cycles after the last pop, `recv_count`=5, `pass`=0.
- `burst_len`=0, `stop` after 100 pushes; then `rst` low during a second run → first run has `recv_count`=100 and `pass`=1; `start` pulses while busy are ignored; reset returns all outputs to 0.

Source files
------------

// File: rtl/uart_tg_pkg.sv
// Shared types and constants for the UART traffic generator/checker.
// Holds the state and pattern-mode encodings plus the LFSR step used by both generators.
package uart_tg_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SEND,
        ST_DRAIN,
        ST_DONE
    } tg_state_t;

    typedef enum logic {
        MODE_LFSR = 1'b0,
        MODE_INCR = 1'b1
    } tg_mode_t;

    localparam logic [15:0] LFSR_MASK = 16'hB400;
    localparam int unsigned DEFAULT_TIMEOUT_CYCLES = 2_000_000;

    // 16-bit Galois LFSR, right shift, feedback from bit 0.
    function automatic logic [15:0] lfsr_step(input logic [15:0] v);
        return v[0] ? ((v >> 1) ^ LFSR_MASK) : (v >> 1);
    endfunction

endpackage

// File: rtl/uart_pattern_gen.sv
// Pattern word source: LFSR or incrementing counter, reloaded on load, stepped on advance.
// One instance feeds the TX path, a second independent one predicts received words.
module uart_pattern_gen
    import uart_tg_pkg::*;
#(
    parameter int unsigned WORD_SIZE = 8,
    parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 load,
    input  logic                 advance,
    input  logic                 mode,
    output logic [WORD_SIZE-1:0] word
);

    logic [15:0]          lfsr_q;
    logic [WORD_SIZE-1:0] incr_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            lfsr_q <= LFSR_SEED;
            incr_q <= '0;
        end else if (load) begin
            lfsr_q <= LFSR_SEED;
            incr_q <= '0;
        end else if (advance) begin
            if (mode == MODE_INCR) begin
                incr_q <= incr_q + 1'b1;
            end else begin
                lfsr_q <= lfsr_step(lfsr_q);
            end
        end
    end

    assign word = (mode == MODE_INCR) ? incr_q : lfsr_q[WORD_SIZE-1:0];

endmodule

// File: rtl/uart_traffic_gen_checker.sv
// Self-checking UART traffic source/sink for one controller port.
// Pushes a pattern burst, pops and checks received words, reports counts, first error and timeout.
module uart_traffic_gen_checker
    import uart_tg_pkg::*;
#(
    parameter int unsigned WORD_SIZE      = 8,
    parameter int unsigned CNT_W          = 16,
    parameter logic [15:0] LFSR_SEED      = 16'hACE1,
    parameter int unsigned TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 stop,
    input  logic                 mode,
    input  logic [CNT_W-1:0]     burst_len,
    input  logic                 tx_full,
    output logic                 write_nic,
    output logic [WORD_SIZE-1:0] data_in,
    input  logic                 read_nic_i,
    input  logic [WORD_SIZE-1:0] data_out,
    output logic                 read_nic,
    output logic                 busy,
    output logic                 done,
    output logic                 pass,
    output logic                 timeout,
    output logic [CNT_W-1:0]     sent_count,
    output logic [CNT_W-1:0]     recv_count,
    output logic [CNT_W-1:0]     err_count,
    output logic [CNT_W-1:0]     first_err_idx,
    output logic [WORD_SIZE-1:0] first_err_exp,
    output logic [WORD_SIZE-1:0] first_err_act
);

    localparam logic [31:0] TIMEOUT_LIM = 32'(TIMEOUT_CYCLES);

    tg_state_t            state_q, state_d;
    tg_mode_t             mode_q, mode_d;
    logic [CNT_W-1:0]     len_q, len_d;
    logic [CNT_W-1:0]     sent_q, sent_d;
    logic [CNT_W-1:0]     recv_q, recv_d;
    logic [CNT_W-1:0]     err_q, err_d;
    logic [CNT_W-1:0]     fidx_q, fidx_d;
    logic [WORD_SIZE-1:0] fexp_q, fexp_d;
    logic [WORD_SIZE-1:0] fact_q, fact_d;
    logic                 timeout_q, timeout_d;
    logic                 pass_q, pass_d;
    logic                 read_q, read_d;
    logic [31:0]          timer_q, timer_d;

    logic                 load, push, accept, check_en, mismatch;
    logic [WORD_SIZE-1:0] tx_word, chk_word;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == '1) ? v : v + 1'b1;
    endfunction

    assign busy     = (state_q == ST_SEND) || (state_q == ST_DRAIN);
    assign load     = start && ((state_q == ST_IDLE) || (state_q == ST_DONE));
    assign push     = (state_q == ST_SEND) && !tx_full && ((len_q == '0) || (sent_q < len_q));
    // read_q masks the word still being popped so each word is examined once.
    assign accept   = read_nic_i && !read_q;
    assign check_en = accept && busy;

    uart_pattern_gen #(.WORD_SIZE(WORD_SIZE), .LFSR_SEED(LFSR_SEED)) u_tx_gen (
        .clk(clk), .rst(rst), .load(load), .advance(push), .mode(mode_q), .word(tx_word)
    );

    uart_pattern_gen #(.WORD_SIZE(WORD_SIZE), .LFSR_SEED(LFSR_SEED)) u_chk_gen (
        .clk(clk), .rst(rst), .load(load), .advance(check_en), .mode(mode_q), .word(chk_word)
    );

    always_comb begin
        state_d   = state_q;
        mode_d    = mode_q;
        len_d     = len_q;
        sent_d    = sent_q;
        recv_d    = recv_q;
        err_d     = err_q;
        fidx_d    = fidx_q;
        fexp_d    = fexp_q;
        fact_d    = fact_q;
        timeout_d = timeout_q;
        pass_d    = pass_q;
        timer_d   = timer_q;
        read_d    = accept;
        mismatch  = 1'b0;

        if (load) begin
            state_d   = ST_SEND;
            mode_d    = tg_mode_t'(mode);
            len_d     = burst_len;
            sent_d    = '0;
            recv_d    = '0;
            err_d     = '0;
            fidx_d    = '0;
            fexp_d    = '0;
            fact_d    = '0;
            timeout_d = 1'b0;
            pass_d    = 1'b0;
            timer_d   = '0;
        end else if (busy) begin
            if (push) begin
                sent_d = sat_inc(sent_q);
            end
            if (check_en) begin
                // A word arriving after everything sent was already received is surplus.
                mismatch = (data_out != chk_word) || ((state_q == ST_DRAIN) && (recv_q == sent_q));
                recv_d   = sat_inc(recv_q);
                timer_d  = '0;
                if (mismatch) begin
                    err_d = sat_inc(err_q);
                    if (err_q == '0) begin
                        fidx_d = recv_q;
                        fexp_d = chk_word;
                        fact_d = data_out;
                    end
                end
            end else if (timer_q != '1) begin
                timer_d = timer_q + 32'd1;
            end

            if (state_q == ST_SEND) begin
                if (stop || ((len_q != '0) && (sent_d == len_q))) begin
                    state_d = ST_DRAIN;
                end
            end else if (recv_q == sent_q) begin
                state_d = ST_DONE;
            end else if (timer_d >= TIMEOUT_LIM) begin
                timeout_d = 1'b1;
                state_d   = ST_DONE;
            end

            if (state_d == ST_DONE) begin
                pass_d = (err_d == '0) && !timeout_d;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= ST_IDLE;
            mode_q    <= MODE_LFSR;
            len_q     <= '0;
            sent_q    <= '0;
            recv_q    <= '0;
            err_q     <= '0;
            fidx_q    <= '0;
            fexp_q    <= '0;
            fact_q    <= '0;
            timeout_q <= 1'b0;
            pass_q    <= 1'b0;
            read_q    <= 1'b0;
            timer_q   <= '0;
        end else begin
            state_q   <= state_d;
            mode_q    <= mode_d;
            len_q     <= len_d;
            sent_q    <= sent_d;
            recv_q    <= recv_d;
            err_q     <= err_d;
            fidx_q    <= fidx_d;
            fexp_q    <= fexp_d;
            fact_q    <= fact_d;
            timeout_q <= timeout_d;
            pass_q    <= pass_d;
            read_q    <= read_d;
            timer_q   <= timer_d;
        end
    end

    assign write_nic     = push;
    assign data_in       = push ? tx_word : '0;
    assign read_nic      = read_q;
    assign done          = (state_q == ST_DONE);
    assign pass          = pass_q;
    assign timeout       = timeout_q;
    assign sent_count    = sent_q;
    assign recv_count    = recv_q;
    assign err_count     = err_q;
    assign first_err_idx = fidx_q;
    assign first_err_exp = fexp_q;
    assign first_err_act = fact_q;

endmodule

// File: tb/tb_uart_traffic_gen_checker.sv
// Bench for uart_traffic_gen_checker: a loopback FIFO stands in for the controller,
// and expected words come from a precomputed pattern table.
module tb_uart_traffic_gen_checker;

    localparam int unsigned WS  = 8;
    localparam int unsigned CW  = 16;
    localparam int unsigned TMO = 50;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          start = 1'b0;
    logic          stop = 1'b0;
    logic          mode = 1'b0;
    logic [CW-1:0] burst_len = '0;
    logic          tx_full = 1'b0;
    logic          read_nic_i = 1'b0;
    logic [WS-1:0] data_out = '0;

    logic          write_nic, read_nic, busy, done, pass, timeout;
    logic [WS-1:0] data_in, first_err_exp, first_err_act;
    logic [CW-1:0] sent_count, recv_count, err_count, first_err_idx;

    uart_traffic_gen_checker #(
        .WORD_SIZE(WS), .CNT_W(CW), .LFSR_SEED(16'hACE1), .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .stop(stop), .mode(mode),
        .burst_len(burst_len), .tx_full(tx_full), .write_nic(write_nic),
        .data_in(data_in), .read_nic_i(read_nic_i), .data_out(data_out),
        .read_nic(read_nic), .busy(busy), .done(done), .pass(pass), .timeout(timeout),
        .sent_count(sent_count), .recv_count(recv_count), .err_count(err_count),
        .first_err_idx(first_err_idx), .first_err_exp(first_err_exp),
        .first_err_act(first_err_act)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Expected word sequence for the current run.
    logic [WS-1:0] model_w [0:511];

    // Environment state (written by the loopback process only).
    logic [WS-1:0] fifo [$];
    logic [WS-1:0] tx_seen [0:511];
    int  pushed = 0;
    int  env_run = 0;
    int  last_pop_cyc = 0;
    int  timeout_cyc = 0;
    bit  timeout_seen = 0;

    // Environment controls (written by the stimulus process only).
    int  run_id = 0;
    int  corrupt_idx = -1;
    int  drop_idx = -1;
    int  stop_at = 0;
    bit  rand_bp = 0;
    bit  force_full = 0;

    int  cyc = 0;
    initial forever begin
        @(posedge clk);
        cyc = cyc + 1;
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic build_model(input logic m);
        logic [15:0] l;
        l = 16'hACE1;
        for (int i = 0; i < 512; i++) begin
            if (m) begin
                model_w[i] = WS'(i % (1 << WS));
            end else begin
                model_w[i] = l[WS-1:0];
                l = l[0] ? ((l >> 1) ^ 16'hB400) : (l >> 1);
            end
        end
    endtask

    // Loopback controller: observes pushes/pops mid-cycle, presents the FIFO head.
    initial forever begin
        logic [WS-1:0] w;
        @(negedge clk);
        if (!rst || env_run != run_id) begin
            fifo.delete();
            pushed = 0;
            timeout_seen = 0;
            last_pop_cyc = 0;
            env_run = run_id;
        end else begin
            if (write_nic) begin
                w = data_in;
                if (pushed < 512) tx_seen[pushed] = w;
                if (pushed == corrupt_idx) w[0] = ~w[0];
                if (pushed != drop_idx) fifo.push_back(w);
                pushed++;
            end
            if (read_nic) begin
                if (fifo.size() > 0) void'(fifo.pop_front());
                last_pop_cyc = cyc;
            end
            if (timeout && !timeout_seen) begin
                timeout_seen = 1;
                timeout_cyc = cyc;
            end
        end
        read_nic_i = (fifo.size() > 0) && (!rand_bp || $urandom_range(0, 3) != 0);
        data_out   = (fifo.size() > 0) ? fifo[0] : '0;
    end

    initial forever begin
        @(posedge clk);
        #1;
        tx_full = force_full || (stop_at > 0 && pushed >= stop_at) ||
                  (rand_bp && $urandom_range(0, 3) == 0);
    end

    task automatic start_run(input logic m, input int len);
        build_model(m);
        @(posedge clk); #1;
        mode = m;
        burst_len = CW'(len);
        start = 1'b1;
        run_id++;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int budget);
        int n;
        n = 0;
        while (done !== 1'b1 && n < budget) begin
            @(negedge clk);
            n++;
        end
        check_eq(tag, done, 1);
        @(negedge clk);
    endtask

    task automatic wait_pushed(input string tag, input int target);
        int n;
        n = 0;
        while (pushed < target && n < 2000) begin
            @(posedge clk); #2;
            n++;
        end
        check_eq(tag, pushed >= target, 1);
    endtask

    task automatic check_zero(input string t);
        check_eq({t, "_write_nic"}, write_nic, 0);
        check_eq({t, "_data_in"}, data_in, 0);
        check_eq({t, "_read_nic"}, read_nic, 0);
        check_eq({t, "_busy"}, busy, 0);
        check_eq({t, "_done"}, done, 0);
        check_eq({t, "_pass"}, pass, 0);
        check_eq({t, "_timeout"}, timeout, 0);
        check_eq({t, "_sent"}, sent_count, 0);
        check_eq({t, "_recv"}, recv_count, 0);
        check_eq({t, "_err"}, err_count, 0);
        check_eq({t, "_fidx"}, first_err_idx, 0);
        check_eq({t, "_fexp"}, first_err_exp, 0);
        check_eq({t, "_fact"}, first_err_act, 0);
    endtask

    task automatic check_result(input string t, input int exp_sent, input int exp_recv,
                                input int exp_err, input logic exp_pass, input logic exp_to);
        check_eq({t, "_sent"}, sent_count, exp_sent);
        check_eq({t, "_recv"}, recv_count, exp_recv);
        check_eq({t, "_err"}, err_count, exp_err);
        check_eq({t, "_pass"}, pass, exp_pass);
        check_eq({t, "_timeout"}, timeout, exp_to);
        check_eq({t, "_busy"}, busy, 0);
        check_eq({t, "_pushed"}, pushed, exp_sent);
        for (int i = 0; i < exp_sent && i < 512; i++)
            check_eq($sformatf("%s_tx_word%0d", t, i), tx_seen[i], model_w[i]);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check_zero("reset");
        rst = 1'b1;

        // Short LFSR burst with start latency check.
        start_run(1'b0, 4);
        check_eq("t1_busy_after_start", busy, 1);
        check_eq("t1_first_push", write_nic, 1);
        wait_done("t1_done", 500);
        check_result("t1", 4, 4, 0, 1'b1, 1'b0);

        // Single corrupted word.
        corrupt_idx = 2;
        start_run(1'b0, 8);
        wait_done("t2_done", 500);
        corrupt_idx = -1;
        check_result("t2", 8, 8, 1, 1'b0, 1'b0);
        check_eq("t2_fidx", first_err_idx, 2);
        check_eq("t2_fexp", first_err_exp, model_w[2]);
        check_eq("t2_fact", first_err_act, model_w[2] ^ 8'h01);

        // Incrementing pattern through the 8-bit wrap.
        start_run(1'b1, 300);
        wait_done("t3_done", 3000);
        check_result("t3", 300, 300, 0, 1'b1, 1'b0);

        // Ten-cycle TX stall mid-burst.
        start_run(1'b0, 16);
        wait_pushed("t4_reach5", 5);
        force_full = 1;
        @(posedge clk);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check_eq($sformatf("t4_stall%0d", i), write_nic, 0);
        end
        force_full = 0;
        wait_done("t4_done", 1000);
        check_result("t4", 16, 16, 0, 1'b1, 1'b0);

        // Last word lost: drain timeout.
        drop_idx = 5;
        start_run(1'b0, 6);
        wait_done("t5_done", 1000);
        drop_idx = -1;
        check_result("t5", 6, 5, 0, 1'b0, 1'b1);
        check_eq("t5_timeout_delay", timeout_cyc - last_pop_cyc, TMO);

        // Continuous run stopped at 100 words, start while busy ignored.
        stop_at = 100;
        start_run(1'($urandom_range(0, 1)), 0);
        wait_pushed("t6_reach50", 50);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(negedge clk);
        check_eq("t6_start_ignored_busy", busy, 1);
        check_eq("t6_start_ignored_cnt", sent_count >= 50, 1);
        wait_pushed("t6_reach100", 100);
        stop = 1'b1;
        @(posedge clk); #1;
        stop = 1'b0;
        wait_done("t6_done", 1000);
        stop_at = 0;
        check_result("t6", 100, 100, 0, 1'b1, 1'b0);

        // Asynchronous reset during a second continuous run.
        start_run(1'b1, 0);
        repeat (20) @(posedge clk);
        #3;
        rst = 1'b0;
        #1;
        check_zero("rst_mid");
        @(posedge clk); #1;
        rst = 1'b1;

        // Randomized bursts under random TX and RX backpressure.
        rand_bp = 1;
        for (int r = 0; r < 4; r++) begin
            logic m;
            int   len;
            m   = 1'($urandom_range(0, 1));
            len = int'($urandom_range(1, 40));
            start_run(m, len);
            wait_done($sformatf("rnd%0d_done", r), 3000);
            check_result($sformatf("rnd%0d", r), len, len, 0, 1'b1, 1'b0);
        end
        rand_bp = 0;

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
